reg_muxn: RTL
=============

REG_MUXN -- requirements
Module: reg_muxn

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits of each input channel and the output.
REQ-002 Parameter NUM_IN, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default 2, select width; SHALL equal ceil(log2(NUM_IN)), minimum 1.
REQ-004 Parameter RESET_VAL, default 32'h00400030, value loaded into out on reset.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_bus  input  NUM_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  channel select.
REQ-009 in_valid  input  1  request to capture the selected channel this cycle.
REQ-010 stall  input  1  hold all registered state.
REQ-011 flush  input  1  invalidate the output.
REQ-012 err_clr  input  1  clear the sticky error flag.
REQ-013 out  output  WIDTH  registered selected data.
REQ-014 out_valid  output  1  out holds a freshly captured value.
REQ-015 sel_err  output  1  sticky flag set by an out-of-range select.
REQ-016 err_cnt  output  8  count of out-of-range selects (see Configuration).

Function
REQ-017 Latency SHALL be exactly one clock: data captured at edge N appears on out after edge N; no combinational path from in_bus or sel to out.
REQ-018 Per-edge priority SHALL be: reset > flush > stall > capture.
REQ-019 flush (reset low) SHALL clear out_valid, hold out, and ignore stall and in_valid that cycle.
REQ-020 stall (reset and flush low) SHALL hold out, out_valid, sel_err and err_cnt unchanged; err_clr is ignored.
REQ-021 Capture: with in_valid=1 and sel<NUM_IN, out SHALL load channel sel and out_valid SHALL be 1.
REQ-022 With in_valid=1 and sel>=NUM_IN, out SHALL hold, out_valid SHALL go 0, sel_err SHALL set to 1.
REQ-023 With in_valid=0, out SHALL hold and out_valid SHALL go 0.
REQ-024 out_valid is the state bit: IDLE (0) -> VALID (1) on legal capture; VALID -> IDLE on flush, in_valid=0 or illegal select; stall holds the state.
REQ-025 err_clr=1 SHALL clear sel_err, unless an illegal select is detected in the same cycle, in which case sel_err SHALL remain 1 (set wins).
REQ-026 When NUM_IN is a power of two, sel is never out of range, and sel_err and err_cnt SHALL stay 0.
REQ-027 sel, in_bus and in_valid SHALL be ignored in any cycle where flush or stall is 1.

Reset
REQ-028 On reset=1 at a rising edge: out=RESET_VAL[WIDTH-1:0], out_valid=0, sel_err=0, err_cnt=0.
REQ-029 Reset SHALL override flush, stall, in_valid and err_clr in the same cycle, including mid-stall.
REQ-030 Outputs SHALL be undefined only before the first reset edge; no initial blocks SHALL be relied upon.

Configuration
REQ-031 Macro REG_MUXN_ERR_CNT_EN: when defined, err_cnt SHALL count illegal selects (REQ-022), saturate at 8'hFF, and clear on err_clr under the same rules as sel_err (set/increment wins, stall holds).
REQ-032 Without REG_MUXN_ERR_CNT_EN, err_cnt SHALL be tied to 8'h00 and no counter logic SHALL be synthesised; all other behaviour is unchanged.

Verification
REQ-033 Reset, then NUM_IN=4, in_bus={D,C,B,A}, sel=2, in_valid=1 -> after one edge out=C, out_valid=1; before the edge out=00400030.
REQ-034 Hold stall=1 for 3 cycles with in_valid=1 and changing sel -> out and out_valid unchanged; release -> capture resumes next edge.
REQ-035 Assert flush and stall together while VALID -> out_valid=0, out unchanged.
REQ-036 NUM_IN=3, sel=3, in_valid=1 -> out holds, out_valid=0, sel_err=1; err_clr alone next cycle -> sel_err=0; err_clr together with sel=3 -> sel_err stays 1.
REQ-037 With REG_MUXN_ERR_CNT_EN, apply 300 illegal selects -> err_cnt=FF; err_clr -> 00. Without the macro -> err_cnt=00 throughout.
REQ-038 Assert reset during stall with out_valid=1 -> out=RESET_VAL, out_valid=0, sel_err=0 after one edge.

Source files
------------

// File: rtl/reg_muxn.sv
// Registered N-to-1 channel mux with stall/flush control and a sticky out-of-range select flag.
// Optional saturating error counter is enabled by defining REG_MUXN_ERR_CNT_EN.
module reg_muxn #(
    parameter int                 WIDTH     = 32,
    parameter int                 NUM_IN    = 4,
    parameter int                 SEL_W     = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = WIDTH'(32'h00400030)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [7:0]              err_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    // Every select code maps to a channel when NUM_IN fills the select space.
    localparam bit SEL_FULL = (NUM_IN == (1 << SEL_W));

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   w_out_nxt;
    logic               r_sel_err;
    logic               w_sel_err_nxt;
    logic [WIDTH-1:0]   w_chan;
    logic               w_sel_oor;
    logic               w_illegal;
    logic               w_advance;

    generate
        if (SEL_FULL) begin : g_sel_full
            assign w_sel_oor = 1'b0;
        end else begin : g_sel_partial
            assign w_sel_oor = (32'(sel) >= 32'(NUM_IN));
        end
    endgenerate

    assign w_illegal = in_valid & w_sel_oor;
    assign w_advance = ~flush & ~stall;

    always_comb begin
        w_chan = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_chan = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt   = r_state;
        w_out_nxt     = r_out;
        w_sel_err_nxt = r_sel_err;

        if (flush) begin
            w_state_nxt = ST_IDLE;
            if (err_clr) begin
                w_sel_err_nxt = 1'b0;
            end
        end else if (!stall) begin
            if (in_valid && !w_sel_oor) begin
                w_out_nxt   = w_chan;
                w_state_nxt = ST_VALID;
            end else begin
                w_state_nxt = ST_IDLE;
            end

            if (w_illegal) begin
                w_sel_err_nxt = 1'b1;
            end else if (err_clr) begin
                w_sel_err_nxt = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_out     <= RESET_VAL;
            r_sel_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out     <= w_out_nxt;
            r_sel_err <= w_sel_err_nxt;
        end
    end

    assign out       = r_out;
    assign out_valid = (r_state == ST_VALID);
    assign sel_err   = r_sel_err;

`ifdef REG_MUXN_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Counter follows the same clear/set priority as the sticky flag; increment wins over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= 8'h00;
        end else if (flush) begin
            if (err_clr) begin
                r_err_cnt <= 8'h00;
            end
        end else if (w_advance) begin
            if (w_illegal) begin
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'h01;
                end
            end else if (err_clr) begin
                r_err_cnt <= 8'h00;
            end
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_adv;
    assign w_unused_adv = w_advance;
    assign err_cnt      = 8'h00;
`endif

endmodule
